wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between three producers: the ALU/jump path, the load-return path and the multi-cycle mul/div unit.
- The ALU/jump path is fixed-latency and cannot be back-pressured except through an explicit stall. The load and mul/div paths are valid/ready and may wait.
- Resolves the write-back source each cycle and forms the write data (ALU result, load data or PC+4).
- Registers the write-port outputs.
- Prevents starvation of the stallable sources by briefly stalling the ALU path.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_starve_cnt.sv | 36 +++
 rtl/wb_port_arbiter.sv | 130 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the write-back port arbiter: result-source encoding,
// grant encoding and the width of the starvation wait counters.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_src_e;

  typedef enum logic [1:0] {
    GNT_ALU  = 2'b00,
    GNT_LD   = 2'b01,
    GNT_MD   = 2'b10,
    GNT_NONE = 2'b11
  } wb_grant_e;

  localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/wb_starve_cnt.sv
// Saturating count of consecutive cycles a stallable source waited while valid.
// starving_o is decoded from the registered count only; never back-pressures.
module wb_starve_cnt
  import wb_pkg::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_i,
  input  logic grant_i,
  output logic starving_o
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (valid_i && !grant_i) begin
      cnt_d = (cnt_q >= LIMIT_C) ? LIMIT_C : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starving_o = (cnt_q >= LIMIT_C);

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between ALU, load and mul/div;
// write is registered (1 cycle after grant); load/mul-div wait via ready, ALU only via stall_alu_o.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid_i,
  input  logic [1:0]            alu_result_src_i,
  input  logic [4:0]            alu_rd_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic [DATA_WIDTH-1:0] alu_pc_i,
  output logic                  stall_alu_o,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [4:0]            ld_rd_i,
  input  logic [DATA_WIDTH-1:0] ld_data_i,
  input  logic                  md_valid_i,
  output logic                  md_ready_o,
  input  logic [4:0]            md_rd_i,
  input  logic [DATA_WIDTH-1:0] md_data_i,
  output logic                  rf_we_o,
  output logic [4:0]            rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic [1:0]            wb_src_o
);

  wb_grant_e             gnt;
  logic                  rr_q, rr_d;
  logic                  ld_starve, md_starve;
  logic                  rf_we_q, rf_we_d;
  logic [4:0]            rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  wb_grant_e             wb_src_q, wb_src_d;
  logic [DATA_WIDTH-1:0] pc_plus4;

  assign stall_alu_o = ld_starve | md_starve;
  assign pc_plus4    = alu_pc_i + DATA_WIDTH'(4);

  // ALU wins unless stalled; rr_q=0 prefers the load when both stallable sources wait.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst_n) begin
      gnt = GNT_NONE;
    end else if (alu_valid_i && !stall_alu_o) begin
      gnt = GNT_ALU;
    end else if (ld_valid_i && md_valid_i) begin
      gnt = rr_q ? GNT_MD : GNT_LD;
    end else if (ld_valid_i) begin
      gnt = GNT_LD;
    end else if (md_valid_i) begin
      gnt = GNT_MD;
    end
  end

  assign ld_ready_o = (gnt == GNT_LD);
  assign md_ready_o = (gnt == GNT_MD);

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    wb_src_d   = GNT_NONE;
    rr_d       = rr_q;
    case (gnt)
      GNT_ALU: begin
        rf_we_d    = (alu_rd_i != 5'd0);
        rf_waddr_d = alu_rd_i;
        rf_wdata_d = (alu_result_src_i == WB_PC4) ? pc_plus4 : alu_result_i;
        wb_src_d   = GNT_ALU;
      end
      GNT_LD: begin
        rf_we_d    = (ld_rd_i != 5'd0);
        rf_waddr_d = ld_rd_i;
        rf_wdata_d = ld_data_i;
        wb_src_d   = GNT_LD;
        rr_d       = 1'b1;
      end
      GNT_MD: begin
        rf_we_d    = (md_rd_i != 5'd0);
        rf_waddr_d = md_rd_i;
        rf_wdata_d = md_data_i;
        wb_src_d   = GNT_MD;
        rr_d       = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_src_q   <= GNT_NONE;
      rr_q       <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wb_src_q   <= wb_src_d;
      rr_q       <= rr_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign wb_src_o   = wb_src_q;

  wb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_ld_wait (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (ld_valid_i),
    .grant_i    (gnt == GNT_LD),
    .starving_o (ld_starve)
  );

  wb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_md_wait (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (md_valid_i),
    .grant_i    (gnt == GNT_MD),
    .starving_o (md_starve)
  );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench: each cycle's expected control and write-port outputs are queued
// by the driver and compared by an independent monitor on the falling edge.
module tb_wb_port_arbiter;

  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          alu_valid;
  logic [1:0]    alu_src;
  logic [4:0]    alu_rd;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] alu_pc;
  logic          stall_alu;
  logic          ld_valid;
  logic          ld_ready;
  logic [4:0]    ld_rd;
  logic [DW-1:0] ld_data;
  logic          md_valid;
  logic          md_ready;
  logic [4:0]    md_rd;
  logic [DW-1:0] md_data;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [1:0]    wb_src;

  typedef struct {
    logic [2:0]    cmb;
    logic          we;
    logic [4:0]    waddr;
    logic [DW-1:0] wdata;
    logic [1:0]    src;
    bit            chk_dat;
    int            idx;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  int   row    = 0;

  wb_port_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alu_valid_i      (alu_valid),
    .alu_result_src_i (alu_src),
    .alu_rd_i         (alu_rd),
    .alu_result_i     (alu_result),
    .alu_pc_i         (alu_pc),
    .stall_alu_o      (stall_alu),
    .ld_valid_i       (ld_valid),
    .ld_ready_o       (ld_ready),
    .ld_rd_i          (ld_rd),
    .ld_data_i        (ld_data),
    .md_valid_i       (md_valid),
    .md_ready_o       (md_ready),
    .md_rd_i          (md_rd),
    .md_data_i        (md_data),
    .rf_we_o          (rf_we),
    .rf_waddr_o       (rf_waddr),
    .rf_wdata_o       (rf_wdata),
    .wb_src_o         (wb_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs observed during the current cycle (write port shows last cycle's grant).
  task automatic ex(input logic st, input logic lr, input logic mr, input logic we,
                    input logic [4:0] a, input logic [DW-1:0] d, input logic [1:0] s,
                    input bit cd);
    exp_t e;
    e.cmb     = {st, lr, mr};
    e.we      = we;
    e.waddr   = a;
    e.wdata   = d;
    e.src     = s;
    e.chk_dat = cd;
    e.idx     = row;
    row++;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_tot++;
        if ({stall_alu, ld_ready, md_ready} === e.cmb) n_pass++;
        else $display("FAIL ctl row %0d: stall/ld_rdy/md_rdy got %b expected %b",
                      e.idx, {stall_alu, ld_ready, md_ready}, e.cmb);
        n_tot++;
        if (rf_we === e.we && wb_src === e.src &&
            (!e.chk_dat || (rf_waddr === e.waddr && rf_wdata === e.wdata))) n_pass++;
        else $display("FAIL wport row %0d: we/addr/data/src got %b/%0d/%h/%b expected %b/%0d/%h/%b",
                      e.idx, rf_we, rf_waddr, rf_wdata, wb_src, e.we, e.waddr, e.wdata, e.src);
      end
    end
  end

  // Driver
  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_src = 2'b00; alu_rd = 5'd0; alu_result = '0; alu_pc = '0;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1111_1111;
    md_valid = 1'b0; md_rd = 5'd0; md_data = '0;

    // reset held with a pending load
    repeat (3) begin tick(); ex(0,0,0, 0,0,32'h0,2'b11,1); end
    tick(); rst_n = 1'b1;                 ex(0,1,0, 0,0,32'h0,2'b11,1);
    tick(); ld_valid = 1'b0;              ex(0,0,0, 1,7,32'h1111_1111,2'b01,1);

    // ALU only: PC+4, PC+4 wrap, result, src=01 as result
    tick(); alu_valid = 1'b1; alu_src = 2'b10; alu_pc = 32'h0000_0100; alu_rd = 5'd5;
            alu_result = 32'h0000_AAAA;   ex(0,0,0, 0,7,32'h1111_1111,2'b11,1);
    tick(); alu_pc = 32'hFFFF_FFFC; alu_rd = 5'd6;
                                          ex(0,0,0, 1,5,32'h0000_0104,2'b00,1);
    tick(); alu_src = 2'b00; alu_result = 32'h1234_5678; alu_rd = 5'd9;
                                          ex(0,0,0, 1,6,32'h0000_0000,2'b00,1);
    tick(); alu_src = 2'b01; alu_result = 32'hCAFE_F00D; alu_rd = 5'd10;
                                          ex(0,0,0, 1,9,32'h1234_5678,2'b00,1);
    tick(); alu_valid = 1'b0;             ex(0,0,0, 1,10,32'hCAFE_F00D,2'b00,1);

    // mid-operation reset with both stallable sources pending, then round-robin
    tick(); rst_n = 1'b0; ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h3333_3333;
            md_valid = 1'b1; md_rd = 5'd4; md_data = 32'h4444_4444;
                                          ex(0,0,0, 0,0,32'h0,2'b11,1);
    tick(); rst_n = 1'b1;                 ex(0,1,0, 0,0,32'h0,2'b11,1);
    tick();                               ex(0,0,1, 1,3,32'h3333_3333,2'b01,1);
    tick();                               ex(0,1,0, 1,4,32'h4444_4444,2'b10,1);
    tick();                               ex(0,0,1, 1,3,32'h3333_3333,2'b01,1);
    tick(); ld_valid = 1'b0; md_valid = 1'b0;
                                          ex(0,0,0, 1,4,32'h4444_4444,2'b10,1);

    // load starved by a continuous ALU stream
    tick(); alu_valid = 1'b1; alu_src = 2'b00; alu_result = 32'h0000_00A0; alu_rd = 5'd1;
            ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 32'h2222_2222;
                                          ex(0,0,0, 0,4,32'h4444_4444,2'b11,1);
    repeat (3) begin tick();              ex(0,0,0, 1,1,32'h0000_00A0,2'b00,1); end
    tick();                               ex(1,1,0, 1,1,32'h0000_00A0,2'b00,1);
    tick();                               ex(0,0,0, 1,2,32'h2222_2222,2'b01,1);

    // single mul/div grant leaves rr pointing at load
    tick(); alu_valid = 1'b0; ld_valid = 1'b0; md_valid = 1'b1; md_rd = 5'd8;
            md_data = 32'h8888_8888;      ex(0,0,1, 1,1,32'h0000_00A0,2'b00,1);

    // both stallable sources starve together
    tick(); alu_valid = 1'b1; ld_valid = 1'b1;
                                          ex(0,0,0, 1,8,32'h8888_8888,2'b10,1);
    repeat (3) begin tick();              ex(0,0,0, 1,1,32'h0000_00A0,2'b00,1); end
    tick();                               ex(1,1,0, 1,1,32'h0000_00A0,2'b00,1);
    tick();                               ex(1,0,1, 1,2,32'h2222_2222,2'b01,1);
    tick();                               ex(0,0,0, 1,8,32'h8888_8888,2'b10,1);
    tick(); alu_valid = 1'b0; ld_valid = 1'b0; md_valid = 1'b0;
                                          ex(0,0,0, 1,1,32'h0000_00A0,2'b00,1);

    // load to x0 is consumed without a write
    tick(); ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hDEAD_BEEF;
                                          ex(0,1,0, 0,1,32'h0000_00A0,2'b11,1);
    tick(); ld_valid = 1'b0;              ex(0,0,0, 0,0,32'h0,2'b01,0);
    tick(); md_valid = 1'b1; md_rd = 5'd12; md_data = 32'h0C0C_0C0C;
                                          ex(0,0,1, 0,0,32'h0,2'b11,0);
    tick(); md_valid = 1'b0;              ex(0,0,0, 1,12,32'h0C0C_0C0C,2'b10,1);
    tick();                               ex(0,0,0, 0,12,32'h0C0C_0C0C,2'b11,1);

    tick();
    tick();
    n_tot++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
